// File: rtl/sysarray_tile_scheduler_if.sv
// Command channel between the tile scheduler and one AXI channel engine:
// a valid/ready command (address + byte count) and a completion pulse.
interface sysarray_tile_scheduler_if #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [C_ADDR_WIDTH-1:0]      cmd_addr;
  logic [C_XFER_SIZE_WIDTH-1:0] cmd_size;
  logic                         done;

  // scheduler side: issues commands, receives ready and completion
  modport master (
    output cmd_valid,
    output cmd_addr,
    output cmd_size,
    input  cmd_ready,
    input  done
  );

  // channel engine side
  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_size,
    output cmd_ready,
    output done
  );
endinterface

// File: rtl/sysarray_tile_scheduler.sv
// Tile-level sequencer for the systolic-array kernel. For each tile it loads
// the input tile (and the weight tile when a new one is needed), pulses the
// array start, stores the output tile, then advances the address cursors.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no run; waiting for ap_start
// S_LOAD    | issue input/weight read commands, wait for both reads done
// S_COMPUTE | compute_start pulsed on entry, waiting for compute_done
// S_STORE   | output write command issued, waiting for handshake and done
// S_NEXT    | advance tile index, cursors and weight-reuse counter
// S_FINISH  | end of run; ap_done pulse follows
module sysarray_tile_scheduler #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_TILE_BYTES      = 16384
) (
  input  logic                     ap_clk,
  input  logic                     areset,
  input  logic                     ap_start,
  output logic                     ap_idle,
  output logic                     ap_done,
  input  logic [31:0]              num_tiles,
  input  logic [31:0]              weight_reuse,
  input  logic [C_ADDR_WIDTH-1:0]  input_base,
  input  logic [C_ADDR_WIDTH-1:0]  weight_base,
  input  logic [C_ADDR_WIDTH-1:0]  output_base,
  sysarray_tile_scheduler_if.master rd0,
  sysarray_tile_scheduler_if.master rd1,
  sysarray_tile_scheduler_if.master wr2,
  output logic                     compute_start,
  input  logic                     compute_done
);

  localparam logic [C_ADDR_WIDTH-1:0]      TILE_A = C_ADDR_WIDTH'(C_TILE_BYTES);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] TILE_S = C_XFER_SIZE_WIDTH'(C_TILE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_STORE,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t                       r_state;
  logic [31:0]                  r_num_tiles;
  logic [31:0]                  r_weight_reuse;
  logic [31:0]                  r_tile_idx;
  logic [31:0]                  r_reuse_cnt;
  logic                         r_need_w;
  logic                         r_load_issued;
  logic                         r_rd0_done_f;
  logic                         r_rd1_done_f;
  logic [C_ADDR_WIDTH-1:0]      r_in_cur;
  logic [C_ADDR_WIDTH-1:0]      r_w_cur;
  logic [C_ADDR_WIDTH-1:0]      r_out_cur;

  logic                         r_rd0_valid;
  logic [C_ADDR_WIDTH-1:0]      r_rd0_addr;
  logic [C_XFER_SIZE_WIDTH-1:0] r_rd0_size;
  logic                         r_rd1_valid;
  logic [C_ADDR_WIDTH-1:0]      r_rd1_addr;
  logic [C_XFER_SIZE_WIDTH-1:0] r_rd1_size;
  logic                         r_wr2_valid;
  logic [C_ADDR_WIDTH-1:0]      r_wr2_addr;
  logic [C_XFER_SIZE_WIDTH-1:0] r_wr2_size;
  logic                         r_compute_start;
  logic                         r_ap_done;
  logic                         r_ap_idle;

  logic                         w_rd0_fire;
  logic                         w_rd1_fire;
  logic                         w_wr2_fire;
  logic                         w_rd0_got;
  logic                         w_rd1_got;
  logic                         w_wr2_got;
  logic [31:0]                  w_tile_nxt;
  logic [31:0]                  w_reuse_nxt;
  logic                         w_w_step;

  // handshakes; a completion counts only once its command has been accepted
  // (or is being accepted this cycle), so early strays cannot end a phase
  assign w_rd0_fire  = r_rd0_valid & rd0.cmd_ready;
  assign w_rd1_fire  = r_rd1_valid & rd1.cmd_ready;
  assign w_wr2_fire  = r_wr2_valid & wr2.cmd_ready;
  assign w_rd0_got   = r_rd0_done_f | (rd0.done & (~r_rd0_valid | w_rd0_fire));
  assign w_rd1_got   = r_rd1_done_f | (rd1.done & (~r_rd1_valid | w_rd1_fire));
  assign w_wr2_got   = wr2.done & (~r_wr2_valid | w_wr2_fire);
  assign w_tile_nxt  = r_tile_idx + 32'd1;
  assign w_reuse_nxt = r_reuse_cnt + 32'd1;
  assign w_w_step    = (r_weight_reuse != 32'd0) && (w_reuse_nxt == r_weight_reuse);

  assign rd0.cmd_valid = r_rd0_valid;
  assign rd0.cmd_addr  = r_rd0_addr;
  assign rd0.cmd_size  = r_rd0_size;
  assign rd1.cmd_valid = r_rd1_valid;
  assign rd1.cmd_addr  = r_rd1_addr;
  assign rd1.cmd_size  = r_rd1_size;
  assign wr2.cmd_valid = r_wr2_valid;
  assign wr2.cmd_addr  = r_wr2_addr;
  assign wr2.cmd_size  = r_wr2_size;
  assign compute_start = r_compute_start;
  assign ap_done       = r_ap_done;
  assign ap_idle       = r_ap_idle;

  // tile sequencer with registered command, pulse and status outputs
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_state         <= S_IDLE;
      r_num_tiles     <= '0;
      r_weight_reuse  <= '0;
      r_tile_idx      <= '0;
      r_reuse_cnt     <= '0;
      r_need_w        <= 1'b0;
      r_load_issued   <= 1'b0;
      r_rd0_done_f    <= 1'b0;
      r_rd1_done_f    <= 1'b0;
      r_in_cur        <= '0;
      r_w_cur         <= '0;
      r_out_cur       <= '0;
      r_rd0_valid     <= 1'b0;
      r_rd0_addr      <= '0;
      r_rd0_size      <= '0;
      r_rd1_valid     <= 1'b0;
      r_rd1_addr      <= '0;
      r_rd1_size      <= '0;
      r_wr2_valid     <= 1'b0;
      r_wr2_addr      <= '0;
      r_wr2_size      <= '0;
      r_compute_start <= 1'b0;
      r_ap_done       <= 1'b0;
      r_ap_idle       <= 1'b1;
    end else begin
      r_compute_start <= 1'b0;
      r_ap_done       <= 1'b0;

      // each command drops the cycle after it is accepted
      if (w_rd0_fire) r_rd0_valid <= 1'b0;
      if (w_rd1_fire) r_rd1_valid <= 1'b0;
      if (w_wr2_fire) r_wr2_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_num_tiles    <= num_tiles;
            r_weight_reuse <= weight_reuse;
            r_in_cur       <= input_base;
            r_w_cur        <= weight_base;
            r_out_cur      <= output_base;
            r_tile_idx     <= '0;
            r_reuse_cnt    <= '0;
            r_need_w       <= 1'b1;
            r_load_issued  <= 1'b0;
            r_rd0_done_f   <= 1'b0;
            r_rd1_done_f   <= 1'b0;
            r_ap_idle      <= 1'b0;
            r_state        <= (num_tiles == 32'd0) ? S_FINISH : S_LOAD;
          end
        end

        S_LOAD: begin
          if (!r_load_issued) begin
            r_load_issued <= 1'b1;
            r_rd0_valid   <= 1'b1;
            r_rd0_addr    <= r_in_cur;
            r_rd0_size    <= TILE_S;
            // weights still resident: treat the weight read as already done
            r_rd1_done_f  <= ~r_need_w;
            if (r_need_w) begin
              r_rd1_valid <= 1'b1;
              r_rd1_addr  <= r_w_cur;
              r_rd1_size  <= TILE_S;
            end
          end else begin
            if (w_rd0_got) r_rd0_done_f <= 1'b1;
            if (w_rd1_got) r_rd1_done_f <= 1'b1;
            if (w_rd0_got && w_rd1_got) begin
              r_compute_start <= 1'b1;
              r_state         <= S_COMPUTE;
            end
          end
        end

        S_COMPUTE: begin
          if (compute_done) begin
            r_wr2_valid <= 1'b1;
            r_wr2_addr  <= r_out_cur;
            r_wr2_size  <= TILE_S;
            r_state     <= S_STORE;
          end
        end

        S_STORE: begin
          if (w_wr2_got) r_state <= S_NEXT;
        end

        S_NEXT: begin
          r_tile_idx    <= w_tile_nxt;
          r_in_cur      <= r_in_cur + TILE_A;
          r_out_cur     <= r_out_cur + TILE_A;
          r_load_issued <= 1'b0;
          r_rd0_done_f  <= 1'b0;
          r_rd1_done_f  <= 1'b0;
          if (w_w_step) begin
            r_reuse_cnt <= '0;
            r_w_cur     <= r_w_cur + TILE_A;
            r_need_w    <= 1'b1;
          end else begin
            r_reuse_cnt <= w_reuse_nxt;
            r_need_w    <= 1'b0;
          end
          r_state <= (w_tile_nxt == r_num_tiles) ? S_FINISH : S_LOAD;
        end

        S_FINISH: begin
          r_ap_done <= 1'b1;
          r_ap_idle <= 1'b1;
          r_state   <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysarray_tile_scheduler.sv
// Bench for sysarray_tile_scheduler: channel/array responders with random
// latencies, plus a tile-list reference model derived from the run scalars.
module tb_sysarray_tile_scheduler;

  localparam logic [63:0] TILE = 64'd16384;

  logic        ap_clk = 1'b0;
  logic        areset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_idle;
  logic        ap_done;
  logic [31:0] num_tiles = '0;
  logic [31:0] weight_reuse = '0;
  logic [63:0] input_base = '0;
  logic [63:0] weight_base = '0;
  logic [63:0] output_base = '0;
  logic        compute_start;
  logic        compute_done = 1'b0;

  sysarray_tile_scheduler_if rd0_if ();
  sysarray_tile_scheduler_if rd1_if ();
  sysarray_tile_scheduler_if wr2_if ();

  sysarray_tile_scheduler dut (
    .ap_clk        (ap_clk),
    .areset        (areset),
    .ap_start      (ap_start),
    .ap_idle       (ap_idle),
    .ap_done       (ap_done),
    .num_tiles     (num_tiles),
    .weight_reuse  (weight_reuse),
    .input_base    (input_base),
    .weight_base   (weight_base),
    .output_base   (output_base),
    .rd0           (rd0_if),
    .rd1           (rd1_if),
    .wr2           (wr2_if),
    .compute_start (compute_start),
    .compute_done  (compute_done)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  logic        rdy[3];
  logic        dn[3];
  logic        w_valid[3];
  logic [63:0] w_addr[3];
  logic [31:0] w_size[3];

  assign rd0_if.cmd_ready = rdy[0];
  assign rd1_if.cmd_ready = rdy[1];
  assign wr2_if.cmd_ready = rdy[2];
  assign rd0_if.done = dn[0];
  assign rd1_if.done = dn[1];
  assign wr2_if.done = dn[2];
  assign w_valid[0] = rd0_if.cmd_valid;
  assign w_valid[1] = rd1_if.cmd_valid;
  assign w_valid[2] = wr2_if.cmd_valid;
  assign w_addr[0] = rd0_if.cmd_addr;
  assign w_addr[1] = rd1_if.cmd_addr;
  assign w_addr[2] = wr2_if.cmd_addr;
  assign w_size[0] = rd0_if.cmd_size;
  assign w_size[1] = rd1_if.cmd_size;
  assign w_size[2] = wr2_if.cmd_size;

  // controls written only by the main sequence
  bit rnd_ready = 1'b0;
  bit sync_done = 1'b0;
  int hold_target = 0;
  int stray_req = 0;

  // observations written only by the responder
  logic [63:0] qa0[$];
  logic [63:0] qa1[$];
  logic [63:0] qa2[$];
  int q_rise0[$];
  int cs_cnt = 0, done_cnt = 0, stab_viol = 0, size_viol = 0;
  int hold_seen = 0, stray_done = 0, valid_cycles = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // channel engines and array core: accept commands, return done pulses
  initial begin : responder
    bit          pw[3];
    bit          pv[3];
    logic [63:0] pa[3];
    logic [31:0] ps[3];
    int          pend[3];
    bit          fired[2];
    int          pend_cd;
    pend_cd = 0;
    for (int c = 0; c < 3; c++) begin
      rdy[c] = 1'b0; dn[c] = 1'b0; pw[c] = 1'b0; pv[c] = 1'b0;
      pa[c] = '0; ps[c] = '0; pend[c] = 0;
    end
    fired[0] = 1'b0; fired[1] = 1'b0;
    forever begin
      @(posedge ap_clk); #1;
      if (areset) begin
        for (int c = 0; c < 3; c++) begin
          rdy[c] = 1'b1; dn[c] = 1'b0; pw[c] = 1'b0; pv[c] = 1'b0; pend[c] = 0;
        end
        fired[0] = 1'b0; fired[1] = 1'b0;
        pend_cd = 0;
        compute_done = 1'b0;
      end else begin
        for (int c = 0; c < 3; c++) begin
          dn[c] = 1'b0;
          if (pend[c] > 0) begin
            pend[c]--;
            if (pend[c] == 0) dn[c] = 1'b1;
          end
          if (c == 0 && hold_seen < hold_target && w_valid[0]) begin
            rdy[0] = 1'b0;
            hold_seen++;
          end else begin
            rdy[c] = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (pw[c] && !(w_valid[c] && w_addr[c] == pa[c] && w_size[c] == ps[c]))
            stab_viol++;
          if (c == 0 && w_valid[0] && !pv[0]) q_rise0.push_back(cyc);
          if (w_valid[c]) valid_cycles++;
          if (w_valid[c] && rdy[c]) begin
            case (c)
              0: qa0.push_back(w_addr[0]);
              1: qa1.push_back(w_addr[1]);
              default: qa2.push_back(w_addr[2]);
            endcase
            if (64'(w_size[c]) != TILE) size_viol++;
            if (sync_done && c < 2) fired[c] = 1'b1;
            else pend[c] = $urandom_range(1, 4);
          end
          pw[c] = w_valid[c] && !rdy[c];
          pv[c] = w_valid[c];
          pa[c] = w_addr[c];
          ps[c] = w_size[c];
        end
        if (fired[0] && fired[1]) begin
          pend[0] = 2; pend[1] = 2;
          fired[0] = 1'b0; fired[1] = 1'b0;
        end
        compute_done = 1'b0;
        if (pend_cd > 0) begin
          pend_cd--;
          if (pend_cd == 0) compute_done = 1'b1;
        end
        if (compute_start) begin
          cs_cnt++;
          pend_cd = $urandom_range(1, 4);
        end
        if (stray_done < stray_req && w_valid[0]) begin
          compute_done = 1'b1;
          stray_done++;
        end
        if (ap_done) done_cnt++;
      end
    end
  end

  // one complete run, compared against the tile lists the scalars imply
  task automatic run(input int nt, input int wr, input logic [63:0] ib,
                     input logic [63:0] wb, input logic [63:0] ob, input bit poke);
    logic [63:0] e0[$];
    logic [63:0] e1[$];
    logic [63:0] e2[$];
    int a0, a1, a2, r0, cs0, d0, sv0, zv0, vc0, c_start, done_c;
    bit got;
    for (int t = 0; t < nt; t++) begin
      e0.push_back(ib + 64'(t) * TILE);
      e2.push_back(ob + 64'(t) * TILE);
      if (wr == 0 ? (t == 0) : (t % wr == 0))
        e1.push_back(wb + 64'(wr == 0 ? 0 : t / wr) * TILE);
    end
    a0 = qa0.size(); a1 = qa1.size(); a2 = qa2.size(); r0 = q_rise0.size();
    cs0 = cs_cnt; d0 = done_cnt; sv0 = stab_viol; zv0 = size_viol; vc0 = valid_cycles;
    num_tiles = 32'(nt); weight_reuse = 32'(wr);
    input_base = ib; weight_base = wb; output_base = ob;
    @(posedge ap_clk); #1;
    ap_start = 1'b1;
    c_start = cyc;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    chk("idle_drop", 64'(ap_idle), 64'd0);
    got = 1'b0;
    done_c = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (ap_done) begin
        got = 1'b1;
        done_c = cyc;
        chk("idle_at_done", 64'(ap_idle), 64'd1);
      end else begin
        if (poke && i == 6) begin ap_start = 1'b1; num_tiles = 32'd7; end
        if (poke && i == 7) begin ap_start = 1'b0; num_tiles = 32'(nt); end
        @(posedge ap_clk); #1;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    if (nt == 0) begin
      chk("done_latency", 64'(done_c), 64'(c_start + 2));
    end else begin
      chk("rd0_latency", (q_rise0.size() > r0) ? 64'(q_rise0[r0]) : 'x, 64'(c_start + 2));
    end
    repeat (3) begin @(posedge ap_clk); #1; end
    chk("rd0_count", 64'(qa0.size() - a0), 64'(e0.size()));
    chk("rd1_count", 64'(qa1.size() - a1), 64'(e1.size()));
    chk("wr2_count", 64'(qa2.size() - a2), 64'(e2.size()));
    foreach (e0[i]) chk("rd0_addr", (a0 + i < qa0.size()) ? qa0[a0 + i] : 'x, e0[i]);
    foreach (e1[i]) chk("rd1_addr", (a1 + i < qa1.size()) ? qa1[a1 + i] : 'x, e1[i]);
    foreach (e2[i]) chk("wr2_addr", (a2 + i < qa2.size()) ? qa2[a2 + i] : 'x, e2[i]);
    chk("compute_starts", 64'(cs_cnt - cs0), 64'(nt));
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("cmd_stable", 64'(stab_viol - sv0), 64'd0);
    chk("cmd_size", 64'(size_viol - zv0), 64'd0);
    if (nt == 0) chk("no_valid", 64'(valid_cycles - vc0), 64'd0);
    chk("idle_after", 64'(ap_idle), 64'd1);
  endtask

  initial begin : main
    int  s0, d0;
    bit  seen;
    repeat (4) @(posedge ap_clk);
    #1;
    chk("rst_idle", 64'(ap_idle), 64'd1);
    chk("rst_done", 64'(ap_done), 64'd0);
    chk("rst_rd0_valid", 64'(rd0_if.cmd_valid), 64'd0);
    chk("rst_rd1_valid", 64'(rd1_if.cmd_valid), 64'd0);
    chk("rst_wr2_valid", 64'(wr2_if.cmd_valid), 64'd0);
    chk("rst_cstart", 64'(compute_start), 64'd0);
    chk("rst_rd0_addr", rd0_if.cmd_addr, 64'd0);
    chk("rst_wr2_size", 64'(wr2_if.cmd_size), 64'd0);
    areset = 1'b0;
    repeat (2) begin @(posedge ap_clk); #1; end

    // single tile, ready tied high
    run(1, 0, 64'h1000, 64'h2000, 64'h3000, 1'b0);
    // weight reuse across pairs of tiles
    run(4, 2, 64'h1000, 64'h2000, 64'h3000, 1'b0);
    // empty run
    run(0, 0, 64'h1000, 64'h2000, 64'h3000, 1'b0);

    // input command back-pressured 10 cycles, read dones coincide
    hold_target = hold_seen + 10;
    sync_done = 1'b1;
    run(1, 0, 64'h5000, 64'h6000, 64'h7000, 1'b0);
    sync_done = 1'b0;
    chk("hold_cycles", 64'(hold_seen), 64'(hold_target));

    // stray compute_done during LOAD and ap_start mid-run
    s0 = stray_done;
    stray_req = stray_req + 1;
    run(3, 1, 64'h10000, 64'h20000, 64'h30000, 1'b1);
    chk("stray_injected", 64'(stray_done - s0), 64'd1);

    // reset while in STORE
    num_tiles = 32'd3; weight_reuse = 32'd0;
    input_base = 64'h1000; weight_base = 64'h2000; output_base = 64'h3000;
    @(posedge ap_clk); #1;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      if (wr2_if.cmd_valid) seen = 1'b1;
      else begin @(posedge ap_clk); #1; end
    end
    chk("store_reached", 64'(seen), 64'd1);
    d0 = done_cnt;
    areset = 1'b1;
    @(posedge ap_clk); #1;
    chk("rst_mid_rd0_valid", 64'(rd0_if.cmd_valid), 64'd0);
    chk("rst_mid_rd1_valid", 64'(rd1_if.cmd_valid), 64'd0);
    chk("rst_mid_wr2_valid", 64'(wr2_if.cmd_valid), 64'd0);
    chk("rst_mid_wr2_addr", wr2_if.cmd_addr, 64'd0);
    chk("rst_mid_idle", 64'(ap_idle), 64'd1);
    @(posedge ap_clk); #1;
    areset = 1'b0;
    repeat (20) begin @(posedge ap_clk); #1; end
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    run(2, 0, 64'h8000, 64'h9000, 64'hA000, 1'b0);

    // address wrap at the top of the address space
    run(3, 1, 64'hFFFF_FFFF_FFFF_C000, 64'hFFFF_FFFF_FFFF_8000,
        64'hFFFF_FFFF_FFFF_C000, 1'b0);

    // randomized runs with random ready back-pressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      run($urandom_range(1, 5), $urandom_range(0, 3), {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    end
    rnd_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sysarray_tile_scheduler.md
Name: sysarray_tile_scheduler

Overview:
Sequences the systolic-array kernel over a run of tiles. Issues per-tile read commands to the input-matrix and weight-matrix channel engines, pulses the array compute start, and issues the output-matrix write command. Sits between the kernel control logic (ap_start/ap_done, scalar args) and the three AXI channel engines plus the array core. Replaces the fixed single-shot start/done fan-out with tile-level sequencing and weight-reuse control.

Parameters:
C_ADDR_WIDTH, 64, width of base/command addresses
C_XFER_SIZE_WIDTH, 32, width of command byte-size fields
C_TILE_BYTES, 16384, bytes per tile per matrix; also the address stride between tiles

Ports:
ap_clk  in  1  clock
areset  in  1  synchronous active-high reset
ap_start  in  1  single-cycle start pulse (already edge-detected)
ap_idle  out  1  high when no run is in progress
ap_done  out  1  single-cycle pulse at end of run
num_tiles  in  32  tiles in the run (scalar00); sampled on accepted start
weight_reuse  in  32  tiles per weight tile (scalar01); 0 = load weights once; sampled on start
input_base  in  C_ADDR_WIDTH  input matrix base; sampled on start
weight_base  in  C_ADDR_WIDTH  weight matrix base; sampled on start
output_base  in  C_ADDR_WIDTH  output matrix base; sampled on start
rd0_cmd_valid / rd0_cmd_ready  out/in  1  input-read command handshake
rd0_cmd_addr  out  C_ADDR_WIDTH  input-read address
rd0_cmd_size  out  C_XFER_SIZE_WIDTH  input-read bytes (always C_TILE_BYTES)
rd0_done  in  1  input-read complete pulse
rd1_cmd_valid / rd1_cmd_ready, rd1_cmd_addr, rd1_cmd_size, rd1_done  same as rd0, weight channel
wr2_cmd_valid / wr2_cmd_ready, wr2_cmd_addr, wr2_cmd_size, wr2_done  same as rd0, output channel
compute_start  out  1  single-cycle array start pulse
compute_done  in  1  array done pulse

Behaviour:
- Reset (sync, any state): state IDLE, ap_idle=1, ap_done=0, all cmd_valid=0, compute_start=0, counters and sticky flags cleared, addr/size outputs 0. Reset mid-run abandons the run; no done pulse.
- States: IDLE, LOAD, COMPUTE, STORE, NEXT, FINISH.
- IDLE: ap_start=1 -> latch scalars and bases; tile_idx=0, reuse_cnt=0, need_w=1; go LOAD (or FINISH if num_tiles=0). ap_idle drops the cycle after ap_start.
- LOAD entry: rd0_cmd_valid=1 (addr = input cursor); rd1_cmd_valid=1 (addr = weight cursor) only if need_w, else weight flag pre-set. Each valid held with stable addr/size until its ready; deasserts the cycle after valid&ready. Sticky flags for rd0_done/rd1_done; leave LOAD when both set (same-cycle dones allowed).
- COMPUTE: compute_start pulses 1 cycle on entry; wait compute_done.
- STORE: wr2_cmd_valid with output cursor; wait handshake then wr2_done.
- NEXT (1 cycle): tile_idx++; input and output cursors += C_TILE_BYTES; reuse_cnt++; if weight_reuse!=0 and reuse_cnt==weight_reuse -> reuse_cnt=0, weight cursor += C_TILE_BYTES, need_w=1, else need_w=0. tile_idx==num_tiles -> FINISH else LOAD.
- FINISH: ap_done=1 one cycle; ap_idle=1 the same cycle; go IDLE.
- Cursors are adders (no multiplier); addresses wrap modulo 2^C_ADDR_WIDTH.
- ap_start while not IDLE: ignored. done/ready pulses outside their waiting state: ignored.
- ready already high when valid rises: one-cycle handshake.
- Latency: start at cycle T -> rd cmd_valid at T+2 (T+1 = IDLE->LOAD register); num_tiles=0 -> ap_done at T+2.

Test Plan:
- num_tiles=1, weight_reuse=0, bases 0x1000/0x2000/0x3000, ready tied 1 -> rd0 addr 0x1000, rd1 0x2000, one compute_start, wr2 0x3000, single ap_done, all sizes 16384.
- num_tiles=4, weight_reuse=2 -> rd1 issued on tiles 0 and 2 only (addr 0x2000, 0x6000); rd0/wr2 addrs step 0x4000; exactly 4 compute_start.
- num_tiles=0 -> no cmd_valid ever, ap_done 2 cycles after ap_start, ap_idle returns 1.
- rd0_cmd_ready held low 10 cycles -> rd0_cmd_valid and addr stable throughout; rd0_done and rd1_done same cycle -> COMPUTE entered once.
- ap_start pulsed mid-run and stray compute_done in LOAD -> no effect on sequence or counts.
- areset asserted in STORE -> next cycle all valids 0, ap_idle=1, no ap_done; new start runs cleanly from tile 0.
